// File: rtl/alu_share_arbiter.sv
// Round-robin valid/ready arbiter sharing one combinational ALU between two requesters.
// Optional grant/contention counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [1:0]          ReqValid,
  output logic [1:0]          ReqReady,
  input  logic [2*DATA_W-1:0] ReqA,
  input  logic [2*DATA_W-1:0] ReqB,
  input  logic [2*OP_W-1:0]   ReqOp,
  output logic [DATA_W-1:0]   AluA,
  output logic [DATA_W-1:0]   AluB,
  output logic [OP_W-1:0]     AluOp,
  input  logic [DATA_W-1:0]   AluOut,
  input  logic                AluZero,
  output logic [1:0]          RspValid,
  input  logic [1:0]          RspReady,
  output logic [DATA_W-1:0]   RspData,
  output logic                RspZero,
  output logic                Busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]         GrantCnt0,
  output logic [15:0]         GrantCnt1,
  output logic [15:0]         ContendCnt
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [1:0]        grant;
  logic              sel;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle) begin
      case (ReqValid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign sel = grant[1];

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_valid_d = rsp_valid_q;
    owner_d     = owner_q;
    last_d      = last_q;
    case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          alu_a_d  = sel ? ReqA[2*DATA_W-1:DATA_W] : ReqA[DATA_W-1:0];
          alu_b_d  = sel ? ReqB[2*DATA_W-1:DATA_W] : ReqB[DATA_W-1:0];
          alu_op_d = sel ? ReqOp[2*OP_W-1:OP_W]    : ReqOp[OP_W-1:0];
          owner_d  = sel;
          last_d   = sel;
          state_d  = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = AluOut;
        rsp_zero_d  = AluZero;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = StResp;
      end
      StResp: begin
        if (RspReady[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 2'b00;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_valid_q <= rsp_valid_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

  assign ReqReady = grant;
  assign AluA     = alu_a_q;
  assign AluB     = alu_b_q;
  assign AluOp    = alu_op_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspZero  = rsp_zero_q;
  assign Busy     = (state_q != StIdle);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;
  logic [15:0] contend_cnt_q, contend_cnt_d;

  always_comb begin
    grant_cnt0_d  = grant_cnt0_q + {15'd0, grant[0]};
    grant_cnt1_d  = grant_cnt1_q + {15'd0, grant[1]};
    contend_cnt_d = contend_cnt_q + {15'd0, (state_q == StIdle) && (ReqValid == 2'b11)};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      grant_cnt0_q  <= '0;
      grant_cnt1_q  <= '0;
      contend_cnt_q <= '0;
    end else begin
      grant_cnt0_q  <= grant_cnt0_d;
      grant_cnt1_q  <= grant_cnt1_d;
      contend_cnt_q <= contend_cnt_d;
    end
  end

  assign GrantCnt0  = grant_cnt0_q;
  assign GrantCnt1  = grant_cnt1_q;
  assign ContendCnt = contend_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU (0=ADD, 1=SUB, 2=AND).
// Counter checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam logic [3:0] KAdd = 4'd0;
  localparam logic [3:0] KSub = 4'd1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [1:0]        ReqValid;
  logic [1:0]        ReqReady;
  logic [15:0]       ReqA, ReqB;
  logic [7:0]        ReqOp;
  logic [7:0]        AluA, AluB;
  logic [3:0]        AluOp;
  logic [7:0]        AluOut;
  logic              AluZero;
  logic [1:0]        RspValid;
  logic [1:0]        RspReady;
  logic [7:0]        RspData;
  logic              RspZero;
  logic              Busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]       GrantCnt0, GrantCnt1, ContendCnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    case (AluOp)
      4'd0:    AluOut = AluA + AluB;
      4'd1:    AluOut = AluA - AluB;
      default: AluOut = AluA & AluB;
    endcase
    AluZero = (AluOut == 8'h00);
  end

  alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqA     (ReqA),
    .ReqB     (ReqB),
    .ReqOp    (ReqOp),
    .AluA     (AluA),
    .AluB     (AluB),
    .AluOp    (AluOp),
    .AluOut   (AluOut),
    .AluZero  (AluZero),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspData  (RspData),
    .RspZero  (RspZero),
    .Busy     (Busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .GrantCnt0  (GrantCnt0),
    .GrantCnt1  (GrantCnt1),
    .ContendCnt (ContendCnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic exp_r1;
    Reset    = 1'b0;
    ReqValid = 2'b00;
    ReqA     = '0;
    ReqB     = '0;
    ReqOp    = '0;
    RspReady = 2'b00;
    #12;
    chk("rst_rspvalid", {30'd0, RspValid}, 32'h0);
    chk("rst_busy", {31'd0, Busy}, 32'h0);
    chk("rst_aluop", {28'd0, AluOp}, 32'h0);
    chk("rst_alua", {24'd0, AluA}, 32'h0);
    chk("rst_rspdata", {24'd0, RspData}, 32'h0);
    tick();
    Reset = 1'b1;
    tick();

    // Single R0 add
    ReqValid = 2'b01;
    ReqA     = 16'h0012;
    ReqB     = 16'h0034;
    ReqOp    = {KSub, KAdd};
    #1;
    chk("r0_ready", {30'd0, ReqReady}, 32'h1);
    tick();
    ReqValid = 2'b00;
    chk("r0_alua", {24'd0, AluA}, 32'h12);
    chk("r0_alub", {24'd0, AluB}, 32'h34);
    chk("r0_aluop", {28'd0, AluOp}, 32'h0);
    chk("r0_busy", {31'd0, Busy}, 32'h1);
    chk("r0_exec_rspvalid", {30'd0, RspValid}, 32'h0);
    tick();
    chk("r0_rspvalid", {30'd0, RspValid}, 32'h1);
    chk("r0_rspdata", {24'd0, RspData}, 32'h46);
    chk("r0_rspzero", {31'd0, RspZero}, 32'h0);

    // Response stall with R0 requesting again and non-owner ready asserted
    ReqValid = 2'b01;
    ReqA     = 16'h00FF;
    RspReady = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rspvalid", {30'd0, RspValid}, 32'h1);
      chk("stall_rspdata", {24'd0, RspData}, 32'h46);
      chk("stall_reqready", {30'd0, ReqReady}, 32'h0);
      chk("stall_alua", {24'd0, AluA}, 32'h12);
    end
    ReqValid = 2'b00;
    RspReady = 2'b01;
    tick();
    RspReady = 2'b00;
    chk("release_rspvalid", {30'd0, RspValid}, 32'h0);
    chk("release_busy", {31'd0, Busy}, 32'h0);

    // R1 subtract giving zero
    ReqValid = 2'b10;
    ReqA     = 16'h5A00;
    ReqB     = 16'h5A00;
    ReqOp    = {KSub, KAdd};
    #1;
    chk("r1_ready", {30'd0, ReqReady}, 32'h2);
    tick();
    ReqValid = 2'b00;
    chk("r1_aluop", {28'd0, AluOp}, 32'h1);
    tick();
    chk("r1_rspvalid", {30'd0, RspValid}, 32'h2);
    chk("r1_rspdata", {24'd0, RspData}, 32'h0);
    chk("r1_rspzero", {31'd0, RspZero}, 32'h1);

    // Reset while in RESP
    #2;
    Reset = 1'b0;
    #1;
    chk("midrst_rspvalid", {30'd0, RspValid}, 32'h0);
    chk("midrst_busy", {31'd0, Busy}, 32'h0);
    chk("midrst_aluop", {28'd0, AluOp}, 32'h0);
    chk("midrst_rspzero", {31'd0, RspZero}, 32'h0);
    tick();
    Reset = 1'b1;
    tick();

    // Contention from reset: R0 first, then alternate
    ReqValid = 2'b11;
    ReqA     = 16'h2010;
    ReqB     = 16'h0301;
    ReqOp    = {KAdd, KAdd};
    RspReady = 2'b11;
    #1;
    exp_r1 = 1'b0;
    for (int g = 0; g < 5; g++) begin
      chk("cont_ready", {30'd0, ReqReady}, exp_r1 ? 32'h2 : 32'h1);
      tick();
      chk("cont_exec_ready", {30'd0, ReqReady}, 32'h0);
      tick();
      chk("cont_rspvalid", {30'd0, RspValid}, exp_r1 ? 32'h2 : 32'h1);
      chk("cont_rspdata", {24'd0, RspData}, exp_r1 ? 32'h23 : 32'h11);
      tick();
      exp_r1 = ~exp_r1;
    end
    ReqValid = 2'b00;
    tick();
    chk("cont_idle_busy", {31'd0, Busy}, 32'h0);

`ifdef ALU_ARB_STATS_EN
    chk("stat_grant0", {16'd0, GrantCnt0}, 32'd3);
    chk("stat_grant1", {16'd0, GrantCnt1}, 32'd2);
    chk("stat_contend", {16'd0, ContendCnt}, 32'd5);
    force dut.grant_cnt0_q = 16'hFFFF;
    #1;
    release dut.grant_cnt0_q;
    chk("stat_preload", {16'd0, GrantCnt0}, 32'hFFFF);
    ReqValid = 2'b01;
    tick();
    ReqValid = 2'b00;
    chk("stat_wrap", {16'd0, GrantCnt0}, 32'h0);
    tick();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
